ecat_dg_logic_parser: RTL and testbench
=======================================

Name: ecat_dg_logic_parser

Overview:
- Upstream neighbour of the FMMU address-mapping stage.
- Parses the EtherCAT datagram byte stream arriving from the frame receiver.
- Extracts the command, the 32-bit logical address and the length from each datagram header.
- For logical-addressed commands (LRD/LWR/LRW), emits one registered 32-bit logical address per data byte, which drives the FMMU mapping input. Chained datagrams (M bit) are handled back to back.

Parameters:
- MAX_DG_LEN, 1486, largest legal datagram data length in bytes; compared against the 11-bit LEN field.
- LOG_ONLY, 1, 1 = data-byte strobes only for logical commands; 0 = strobes for all commands.

Ports:
- clk  input  1  single system clock
- rst  input  1  asynchronous, active-high reset
- rx_sof  input  1  qualifies rx_data as first byte of first datagram header
- rx_valid  input  1  byte strobe; no backpressure (wire rate)
- rx_data  input  8  received byte
- rx_eof  input  1  frame ended (after FCS); sampled with or without rx_valid
- dg_cmd  output  8  command byte of current datagram, held until next header
- dg_is_logic  output  1  dg_cmd is 0x0A, 0x0B or 0x0C
- dg_len  output  11  LEN field of current datagram
- dg_more  output  1  M bit (bit 15 of length word)
- log_addr  output  32  logical address of current data byte
- data_byte  output  8  data byte aligned with log_addr
- data_valid  output  1  data byte strobe
- data_first  output  1  first data byte of datagram
- data_last  output  1  last data byte of datagram
- wkc_valid  output  1  strobe per WKC byte (two per datagram)
- dg_done  output  1  one-cycle pulse after second WKC byte
- dg_err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, CMD, IDX, ADR0..ADR3, LEN0, LEN1, IRQ0, IRQ1, DATA, WKC0, WKC1.
- IDLE -> IDX on rx_valid&rx_sof; that byte is latched as dg_cmd. The CMD state is entered only via chaining.
- Each header state advances on rx_valid. Address bytes are little-endian: ADR0 = bits 7:0 … ADR3 = bits 31:24. LEN0/LEN1 are little-endian; len = word[10:0], more = word[15].
- Header outputs (dg_cmd, dg_is_logic, dg_len, dg_more) update at the end of LEN1.
- After IRQ1: go to DATA if len > 0, else to WKC0.
- DATA, per rx_valid byte k (0-based):
  - log_addr = addr_start + k (32-bit wrap, modulo 2^32).
  - data_byte = rx_data.
  - data_valid = 1 (gated by dg_is_logic when LOG_ONLY = 1).
  - data_first = (k == 0); data_last = (k == len-1).
  - All registered: 1-cycle latency from the input byte.
- k is an 11-bit counter. DATA -> WKC0 after byte len-1.
- WKC0, WKC1: wkc_valid per byte. After WKC1, dg_done pulses for 1 cycle, then:
  - dg_more = 1 -> CMD (next byte is a new header, no rx_sof needed);
  - dg_more = 0 -> IDLE.
- rx_sof in any non-IDLE state: dg_err pulses, the byte is treated as a new command byte, and the FSM goes to IDX (resync).
- rx_eof in any state other than IDLE or the state following WKC1: dg_err pulses, the FSM goes to IDLE, no dg_done.
- rx_eof in the same cycle as the last WKC byte is legal: dg_done is asserted and the FSM goes to IDLE even if more = 1.
- rx_valid low: hold state; outputs strobes low.
- Asynchronous rst mid-datagram: immediate return to reset values; the partial datagram is discarded.

Optional Feature:
- Macro: ECAT_DG_LEN_CHECK_EN.
- Defined: at LEN1, len > MAX_DG_LEN -> dg_err pulse, no data_valid strobes for that frame, FSM goes to a DROP state until rx_eof, then IDLE.
- Undefined: no length check; DROP state absent; oversized lengths are parsed as-is.

Decomposition:
- Package ecat_pkg holds:
  - command constants CMD_LRD = 8'h0A, CMD_LWR = 8'h0B, CMD_LRW = 8'h0C;
  - header byte count constant HDR_BYTES = 10, WKC_BYTES = 2;
  - state enum typedef;
  - LEN field width constant 11.
- No sub-module required. Header capture and data-address counting stay in one FSM file. The FMMU mapper instantiates alongside and consumes log_addr/data_valid.

Test Plan:
- LRD, addr 0x00010000, len 4, M = 0:
  - log_addr 0x00010000..0x00010003 with data_first on byte 0 and data_last on byte 3;
  - two wkc_valid strobes, then dg_done.
- Addr 0xFFFFFFFE, len 3 -> log_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
- Two chained datagrams (LWR M = 1 len 2 at 0x100, LRW M = 0 len 1 at 0x200):
  - log_addr 0x100, 0x101, then 0x200;
  - two dg_done pulses; no rx_sof between datagrams.
- APRD (0x01) len 2 with LOG_ONLY = 1 -> dg_is_logic = 0, no data_valid, dg_done still pulses.
- rx_eof after 2 of 4 data bytes -> dg_err pulse, no dg_done, FSM in IDLE; next rx_sof frame parses correctly.
- With ECAT_DG_LEN_CHECK_EN, len 1500 > 1486 -> dg_err at LEN1, no data_valid until rx_eof. Without the macro, 1500 bytes are strobed.

Source files
------------

// File: rtl/ecat_pkg.sv
// Shared definitions for the EtherCAT datagram parser: command codes,
// header/WKC byte counts, LEN field width and the parser state type.
// The DROP state only exists when ECAT_DG_LEN_CHECK_EN is defined.
package ecat_pkg;

  localparam logic [7:0] CMD_LRD = 8'h0A;
  localparam logic [7:0] CMD_LWR = 8'h0B;
  localparam logic [7:0] CMD_LRW = 8'h0C;

  localparam int HDR_BYTES = 10;
  localparam int WKC_BYTES = 2;
  localparam int LEN_W     = 11;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    IDX,
    ADR0,
    ADR1,
    ADR2,
    ADR3,
    LEN0,
    LEN1,
    IRQ0,
    IRQ1,
    DATA,
    WKC0,
    WKC1
`ifdef ECAT_DG_LEN_CHECK_EN
    ,
    DROP
`endif
  } dg_state_t;

  // True for the logical-addressed commands that the FMMU stage maps.
  function automatic logic is_logic_cmd(input logic [7:0] cmd);
    return (cmd == CMD_LRD) || (cmd == CMD_LWR) || (cmd == CMD_LRW);
  endfunction

endpackage

// File: rtl/ecat_dg_logic_parser.sv
// EtherCAT datagram header parser and logical-address generator.
// Walks the datagram byte stream, captures command/address/length and
// emits one registered logical address per data byte for the FMMU mapper.
// Optional oversize-length drop: define ECAT_DG_LEN_CHECK_EN.
module ecat_dg_logic_parser #(
  parameter int MAX_DG_LEN = 1486,
  parameter bit LOG_ONLY   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_sof,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_eof,
  output logic [7:0]  dg_cmd,
  output logic        dg_is_logic,
  output logic [10:0] dg_len,
  output logic        dg_more,
  output logic [31:0] log_addr,
  output logic [7:0]  data_byte,
  output logic        data_valid,
  output logic        data_first,
  output logic        data_last,
  output logic        wkc_valid,
  output logic        dg_done,
  output logic        dg_err
);

  import ecat_pkg::*;

`ifdef ECAT_DG_LEN_CHECK_EN
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_DG_LEN);
`endif

  dg_state_t         state_q, state_n;
  logic [7:0]        cmd_q, cmd_n;
  logic [31:0]       addr_q, addr_n;
  logic [7:0]        len_lo_q, len_lo_n;
  logic [LEN_W-1:0]  cnt_q, cnt_n;

  logic [7:0]        dg_cmd_n;
  logic              dg_is_logic_n;
  logic [LEN_W-1:0]  dg_len_n;
  logic              dg_more_n;
  logic [31:0]       log_addr_n;
  logic [7:0]        data_byte_n;
  logic              data_valid_n, data_first_n, data_last_n;
  logic              wkc_valid_n, dg_done_n, dg_err_n;
  logic              eof_quiet, in_drop, byte_on, last_byte;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state and next-value logic: framing errors first, then byte parsing.
  always_comb begin
    state_n       = state_q;
    cmd_n         = cmd_q;
    addr_n        = addr_q;
    len_lo_n      = len_lo_q;
    cnt_n         = cnt_q;
    dg_cmd_n      = dg_cmd;
    dg_is_logic_n = dg_is_logic;
    dg_len_n      = dg_len;
    dg_more_n     = dg_more;
    log_addr_n    = log_addr;
    data_byte_n   = data_byte;
    data_valid_n  = 1'b0;
    data_first_n  = 1'b0;
    data_last_n   = 1'b0;
    wkc_valid_n   = 1'b0;
    dg_done_n     = 1'b0;
    dg_err_n      = 1'b0;
    byte_on       = 1'b0;
    last_byte     = 1'b0;
    eof_quiet     = (state_q == CMD);
    in_drop       = 1'b0;
`ifdef ECAT_DG_LEN_CHECK_EN
    if (state_q == DROP) begin
      eof_quiet = 1'b1;
      in_drop   = 1'b1;
    end
`endif

    if (state_q == IDLE) begin
      if (rx_valid && rx_sof) begin
        cmd_n   = rx_data;
        state_n = IDX;
      end
    end else if (rx_eof) begin
      if (state_q == WKC1 && rx_valid) begin
        wkc_valid_n = 1'b1;
        dg_done_n   = 1'b1;
      end else if (!eof_quiet) begin
        dg_err_n = 1'b1;
      end
      state_n = IDLE;
    end else if (rx_valid && rx_sof && !in_drop) begin
      dg_err_n = 1'b1;
      cmd_n    = rx_data;
      state_n  = IDX;
    end else if (rx_valid) begin
      case (state_q)
        CMD: begin
          cmd_n   = rx_data;
          state_n = IDX;
        end
        IDX:  state_n = ADR0;
        ADR0: begin addr_n[7:0]   = rx_data; state_n = ADR1; end
        ADR1: begin addr_n[15:8]  = rx_data; state_n = ADR2; end
        ADR2: begin addr_n[23:16] = rx_data; state_n = ADR3; end
        ADR3: begin addr_n[31:24] = rx_data; state_n = LEN0; end
        LEN0: begin len_lo_n = rx_data; state_n = LEN1; end
        LEN1: begin
          dg_cmd_n      = cmd_q;
          dg_is_logic_n = is_logic_cmd(cmd_q);
          dg_len_n      = {rx_data[2:0], len_lo_q};
          dg_more_n     = rx_data[7];
          state_n       = IRQ0;
`ifdef ECAT_DG_LEN_CHECK_EN
          if ({rx_data[2:0], len_lo_q} > MAX_LEN_C) begin
            dg_err_n = 1'b1;
            state_n  = DROP;
          end
`endif
        end
        IRQ0: state_n = IRQ1;
        IRQ1: begin
          cnt_n   = '0;
          state_n = (dg_len != '0) ? DATA : WKC0;
        end
        DATA: begin
          byte_on      = LOG_ONLY ? dg_is_logic : 1'b1;
          last_byte    = (cnt_q == dg_len - 11'd1);
          log_addr_n   = addr_q + 32'(cnt_q);
          data_byte_n  = rx_data;
          data_valid_n = byte_on;
          data_first_n = byte_on && (cnt_q == '0);
          data_last_n  = byte_on && last_byte;
          cnt_n        = cnt_q + 11'd1;
          if (last_byte) state_n = WKC0;
        end
        WKC0: begin
          wkc_valid_n = 1'b1;
          state_n     = WKC1;
        end
        WKC1: begin
          wkc_valid_n = 1'b1;
          dg_done_n   = 1'b1;
          state_n     = dg_more ? CMD : IDLE;
        end
        default: ;
      endcase
    end
  end

  // Header capture, address counter and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q       <= '0;
      addr_q      <= '0;
      len_lo_q    <= '0;
      cnt_q       <= '0;
      dg_cmd      <= '0;
      dg_is_logic <= 1'b0;
      dg_len      <= '0;
      dg_more     <= 1'b0;
      log_addr    <= '0;
      data_byte   <= '0;
      data_valid  <= 1'b0;
      data_first  <= 1'b0;
      data_last   <= 1'b0;
      wkc_valid   <= 1'b0;
      dg_done     <= 1'b0;
      dg_err      <= 1'b0;
    end else begin
      cmd_q       <= cmd_n;
      addr_q      <= addr_n;
      len_lo_q    <= len_lo_n;
      cnt_q       <= cnt_n;
      dg_cmd      <= dg_cmd_n;
      dg_is_logic <= dg_is_logic_n;
      dg_len      <= dg_len_n;
      dg_more     <= dg_more_n;
      log_addr    <= log_addr_n;
      data_byte   <= data_byte_n;
      data_valid  <= data_valid_n;
      data_first  <= data_first_n;
      data_last   <= data_last_n;
      wkc_valid   <= wkc_valid_n;
      dg_done     <= dg_done_n;
      dg_err      <= dg_err_n;
    end
  end

endmodule

// File: tb/tb_ecat_dg_logic_parser.sv
// Randomised self-checking bench for ecat_dg_logic_parser.
// Frames are described as lists of datagrams; a reference model derives the
// expected data events, WKC strobes, done and error pulses from those lists.
`timescale 1ns/1ps
module tb_ecat_dg_logic_parser;

  import ecat_pkg::*;

  localparam int MAX_LEN     = 1486;
  localparam bit LOG_ONLY_TB = 1'b1;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [10:0] len;
    logic        more;
  } dg_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        first;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_sof, rx_valid, rx_eof;
  logic [7:0]  rx_data;
  logic [7:0]  dg_cmd;
  logic        dg_is_logic;
  logic [10:0] dg_len;
  logic        dg_more;
  logic [31:0] log_addr;
  logic [7:0]  data_byte;
  logic        data_valid, data_first, data_last;
  logic        wkc_valid, dg_done, dg_err;

  ecat_dg_logic_parser #(.MAX_DG_LEN(MAX_LEN), .LOG_ONLY(LOG_ONLY_TB)) dut (
    .clk(clk), .rst(rst),
    .rx_sof(rx_sof), .rx_valid(rx_valid), .rx_data(rx_data), .rx_eof(rx_eof),
    .dg_cmd(dg_cmd), .dg_is_logic(dg_is_logic), .dg_len(dg_len), .dg_more(dg_more),
    .log_addr(log_addr), .data_byte(data_byte), .data_valid(data_valid),
    .data_first(data_first), .data_last(data_last),
    .wkc_valid(wkc_valid), .dg_done(dg_done), .dg_err(dg_err)
  );

  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  dg_t         frame_dgs[$];
  logic [7:0]  byte_q[$];
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          exp_wkc, exp_done, exp_err;
  int          obs_wkc = 0, obs_done = 0, obs_err = 0;
  logic [7:0]  hdr_cmd;
  logic [10:0] hdr_len;
  logic        hdr_more;
  logic [7:0]  cmd_pool[6] = '{8'h0A, 8'h0B, 8'h0C, 8'h01, 8'h04, 8'h07};

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Collect everything the parser emits, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) obs_q.push_back({log_addr, data_byte, data_first, data_last});
      if (wkc_valid) obs_wkc++;
      if (dg_done)   obs_done++;
      if (dg_err)    obs_err++;
    end
  end

  task automatic addDg(input logic [7:0] cmd, input logic [31:0] addr,
                       input int len, input bit more);
    dg_t d;
    d.cmd  = cmd;
    d.addr = addr;
    d.len  = 11'(len);
    d.more = more;
    frame_dgs.push_back(d);
  endtask

  // Serialise the datagram list into the wire byte order.
  task automatic buildBytes();
    byte_q.delete();
    foreach (frame_dgs[i]) begin
      dg_t d;
      d = frame_dgs[i];
      byte_q.push_back(d.cmd);
      byte_q.push_back(8'($urandom));
      for (int b = 0; b < 4; b++) byte_q.push_back(d.addr[8*b +: 8]);
      byte_q.push_back(d.len[7:0]);
      byte_q.push_back({d.more, 4'($urandom), d.len[10:8]});
      byte_q.push_back(8'($urandom));
      byte_q.push_back(8'($urandom));
      for (int k = 0; k < int'(d.len); k++) byte_q.push_back(8'($urandom));
      for (int w = 0; w < WKC_BYTES; w++) byte_q.push_back(8'($urandom));
    end
  endtask

  // Reference model: what the parser should emit when only the first n bytes
  // of the frame arrive before end of frame.
  task automatic computeExpect(input int n);
    int p;
    p = 0;
    exp_q.delete();
    exp_wkc  = 0;
    exp_done = 0;
    exp_err  = 0;
    foreach (frame_dgs[i]) begin
      dg_t d;
      int  avail;
      bit  logic_cmd;
      d = frame_dgs[i];
      if (p >= n) break;
      avail     = n - p;
      logic_cmd = d.cmd inside {CMD_LRD, CMD_LWR, CMD_LRW};
      if (avail >= HDR_BYTES - 2) begin
        hdr_cmd  = d.cmd;
        hdr_len  = d.len;
        hdr_more = d.more;
      end
`ifdef ECAT_DG_LEN_CHECK_EN
      if (avail >= HDR_BYTES - 2 && int'(d.len) > MAX_LEN) begin
        exp_err++;
        break;
      end
`endif
      for (int k = 0; k < int'(d.len) && HDR_BYTES + k < avail; k++)
        if (logic_cmd || !LOG_ONLY_TB)
          exp_q.push_back({d.addr + 32'(k), byte_q[p + HDR_BYTES + k],
                           (k == 0), (k == int'(d.len) - 1)});
      for (int w = 0; w < WKC_BYTES; w++)
        if (HDR_BYTES + int'(d.len) + w < avail) exp_wkc++;
      if (avail >= HDR_BYTES + int'(d.len) + WKC_BYTES) exp_done++;
      else begin
        exp_err++;
        break;
      end
      p += HDR_BYTES + int'(d.len) + WKC_BYTES;
    end
  endtask

  // Drive n bytes at wire rate with occasional idle cycles, then end the frame.
  task automatic applyStimulus(input int n, input bit eof_on_last, input bit send_eof);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'($urandom);
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = byte_q[i];
      rx_sof   = (i == 0);
      rx_eof   = send_eof && eof_on_last && (i == n - 1);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    if (send_eof) begin
      if (!eof_on_last) begin
        rx_eof = 1'b1;
        @(posedge clk); #1;
        rx_eof = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, " data_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      checkOutput({tag, " data_event"}, 64'(obs_q[i]), 64'(exp_q[i]));
    checkOutput({tag, " wkc_count"},  64'(obs_wkc),  64'(exp_wkc));
    checkOutput({tag, " done_count"}, 64'(obs_done), 64'(exp_done));
    checkOutput({tag, " err_count"},  64'(obs_err),  64'(exp_err));
    checkOutput({tag, " dg_cmd"},  64'(dg_cmd),  64'(hdr_cmd));
    checkOutput({tag, " dg_len"},  64'(dg_len),  64'(hdr_len));
    checkOutput({tag, " dg_more"}, 64'(dg_more), 64'(hdr_more));
    checkOutput({tag, " dg_is_logic"}, 64'(dg_is_logic),
                64'(hdr_cmd inside {CMD_LRD, CMD_LWR, CMD_LRW}));
    obs_q.delete();
    obs_wkc  = 0;
    obs_done = 0;
    obs_err  = 0;
    frame_dgs.delete();
  endtask

  task automatic runFrame(input string tag, input int n_limit, input bit eof_on_last);
    int n;
    buildBytes();
    n = (n_limit < 0) ? byte_q.size() : n_limit;
    computeExpect(n);
    applyStimulus(n, eof_on_last, 1'b1);
    checkFrame(tag);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx_sof = 1'b0; rx_valid = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
    hdr_cmd = 8'h00; hdr_len = 11'd0; hdr_more = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset data_strobes", 64'({data_valid, data_first, data_last, wkc_valid, dg_done, dg_err}), 64'd0);
    checkOutput("reset log_addr", 64'(log_addr), 64'd0);
    checkOutput("reset header", 64'({dg_cmd, dg_is_logic, dg_len, dg_more}), 64'd0);
    checkOutput("reset data_byte", 64'(data_byte), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    addDg(CMD_LRD, 32'h0001_0000, 4, 1'b0);
    runFrame("lrd_len4", -1, 1'b0);

    addDg(CMD_LRD, 32'hFFFF_FFFE, 3, 1'b0);
    runFrame("addr_wrap", -1, 1'b0);

    addDg(CMD_LWR, 32'h0000_0100, 2, 1'b1);
    addDg(CMD_LRW, 32'h0000_0200, 1, 1'b0);
    runFrame("chained", -1, 1'b0);

    addDg(8'h01, 32'h0000_1234, 2, 1'b0);
    runFrame("aprd_nonlogic", -1, 1'b0);

    addDg(CMD_LRD, 32'h0000_4000, 4, 1'b0);
    runFrame("eof_abort", HDR_BYTES + 2, 1'b0);

    addDg(CMD_LWR, 32'h0000_5000, 3, 1'b0);
    runFrame("after_abort", -1, 1'b0);

    addDg(CMD_LRW, 32'h0000_6000, 3, 1'b1);
    runFrame("eof_on_wkc_more", -1, 1'b1);

    addDg(CMD_LRD, 32'h0000_0000, 0, 1'b0);
    runFrame("len_zero", -1, 1'b0);

    addDg(CMD_LRD, 32'h0000_1000, 1500, 1'b0);
    runFrame("len_1500", -1, 1'b0);

    // Asynchronous reset in the middle of the data phase.
    addDg(CMD_LRW, 32'hABCD_0000, 8, 1'b0);
    buildBytes();
    applyStimulus(HDR_BYTES + 3, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset strobes", 64'({data_valid, wkc_valid, dg_done, dg_err}), 64'd0);
    checkOutput("midreset header", 64'({dg_cmd, dg_len, dg_more}), 64'd0);
    checkOutput("midreset log_addr", 64'(log_addr), 64'd0);
    obs_q.delete();
    obs_wkc = 0; obs_done = 0; obs_err = 0;
    frame_dgs.delete();
    hdr_cmd = 8'h00; hdr_len = 11'd0; hdr_more = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    addDg(CMD_LRD, 32'h0000_7700, 5, 1'b0);
    runFrame("after_midreset", -1, 1'b0);

    // Random multi-datagram frames, some truncated by an early end of frame.
    for (int f = 0; f < 25; f++) begin
      int ndg, total, n;
      ndg = $urandom_range(1, 3);
      for (int i = 0; i < ndg; i++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
        addDg(cmd_pool[$urandom_range(0, 5)], a, $urandom_range(0, 10), (i < ndg - 1));
      end
      buildBytes();
      total = byte_q.size();
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, total - 1) : total;
      computeExpect(n);
      applyStimulus(n, (n == total) && ($urandom_range(0, 1) == 1), 1'b1);
      checkFrame($sformatf("random%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
